// File: rtl/sordm5_ps2_matrix.sv
// PS/2 set-2 event stream to Sord M5 8x8 key matrix, plus RESET-key NMI pulse generator.
// Optional macro KBD_SHIFTLOCK_EN adds a CapsLock-driven shift-lock that reads as LSHIFT (r0c2).
module sordm5_ps2_matrix #(
  parameter int unsigned NMI_PULSE_CYCLES = 16,
  parameter logic [7:0]  RESET_KEY_CODE   = 8'h69
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [10:0] ps2_key_i,
  input  logic [2:0]  key_row_i,
  output logic [7:0]  key_cols_o,
  output logic        any_key_o,
  output logic        reset_key_o,
  output logic        nmi_req_o
);

  localparam logic [7:0] NMI_LOAD = 8'(NMI_PULSE_CYCLES);

  // Stage 1: toggle-edge capture
  logic       init_q;
  logic       tog_q;
  logic       ev_valid_q;
  logic       ev_pressed_q;
  logic       ev_ext_q;
  logic [7:0] ev_code_q;

  // Stage 2: decoded event
  logic       dec_hit_q;
  logic       dec_rst_q;
  logic       dec_pressed_q;
  logic [5:0] dec_cell_q;

  // Stage 3: matrix and RESET-key state
  logic [7:0][7:0] matrix_q;
  logic            any_key_q;
  logic            reset_key_q;
  logic [7:0]      nmi_cnt_q;
  logic [7:0]      nmi_cnt_d;

  logic       lut_hit;
  logic [5:0] lut_cell;
  logic       is_rst_key;

`ifdef KBD_SHIFTLOCK_EN
  logic dec_caps_q;
  logic shift_lock_q;
  logic caps_held_q;
  logic is_caps;
  assign is_caps = !ev_ext_q && (ev_code_q == 8'h58);
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      init_q       <= 1'b0;
      tog_q        <= 1'b0;
      ev_valid_q   <= 1'b0;
      ev_pressed_q <= 1'b0;
      ev_ext_q     <= 1'b0;
      ev_code_q    <= 8'h00;
    end else begin
      // The first clock after reset only seeds the history, so no event is fabricated.
      init_q       <= 1'b1;
      tog_q        <= ps2_key_i[10];
      ev_valid_q   <= init_q && (ps2_key_i[10] != tog_q);
      ev_pressed_q <= ps2_key_i[9];
      ev_ext_q     <= ps2_key_i[8];
      ev_code_q    <= ps2_key_i[7:0];
    end
  end

  assign is_rst_key = ev_ext_q && (ev_code_q == RESET_KEY_CODE);

  // Cell encoding is octal {row, col}.
  always_comb begin
    lut_hit  = 1'b1;
    lut_cell = 6'o00;
    case ({ev_ext_q, ev_code_q})
      9'h014, 9'h114: lut_cell = 6'o00;
      9'h011, 9'h111: lut_cell = 6'o01;
      9'h012: lut_cell = 6'o02;
      9'h059: lut_cell = 6'o03;
      9'h076: lut_cell = 6'o04;
      9'h066: lut_cell = 6'o05;
      9'h029: lut_cell = 6'o06;
      9'h05A: lut_cell = 6'o07;
      9'h016: lut_cell = 6'o10;
      9'h01E: lut_cell = 6'o11;
      9'h026: lut_cell = 6'o12;
      9'h025: lut_cell = 6'o13;
      9'h02E: lut_cell = 6'o14;
      9'h036: lut_cell = 6'o15;
      9'h03D: lut_cell = 6'o16;
      9'h03E: lut_cell = 6'o17;
      9'h01C: lut_cell = 6'o20;
      9'h01B: lut_cell = 6'o21;
      9'h023: lut_cell = 6'o22;
      9'h02B: lut_cell = 6'o23;
      9'h034: lut_cell = 6'o24;
      9'h033: lut_cell = 6'o25;
      9'h03B: lut_cell = 6'o26;
      9'h042: lut_cell = 6'o27;
      9'h015: lut_cell = 6'o30;
      9'h01D: lut_cell = 6'o31;
      9'h024: lut_cell = 6'o32;
      9'h02D: lut_cell = 6'o33;
      9'h02C: lut_cell = 6'o34;
      9'h035: lut_cell = 6'o35;
      9'h03C: lut_cell = 6'o36;
      9'h043: lut_cell = 6'o37;
      9'h01A: lut_cell = 6'o40;
      9'h022: lut_cell = 6'o41;
      9'h021: lut_cell = 6'o42;
      9'h02A: lut_cell = 6'o43;
      9'h032: lut_cell = 6'o44;
      9'h031: lut_cell = 6'o45;
      9'h03A: lut_cell = 6'o46;
      9'h041: lut_cell = 6'o47;
      9'h046: lut_cell = 6'o50;
      9'h045: lut_cell = 6'o51;
      9'h04E: lut_cell = 6'o52;
      9'h055: lut_cell = 6'o53;
      9'h049: lut_cell = 6'o54;
      9'h04A: lut_cell = 6'o55;
      9'h05D: lut_cell = 6'o56;
      9'h00E: lut_cell = 6'o57;
      9'h044: lut_cell = 6'o60;
      9'h04D: lut_cell = 6'o61;
      9'h054: lut_cell = 6'o62;
      9'h05B: lut_cell = 6'o63;
      9'h04B: lut_cell = 6'o64;
      9'h04C: lut_cell = 6'o65;
      9'h052: lut_cell = 6'o66;
      9'h00D: lut_cell = 6'o67;
      9'h175: lut_cell = 6'o70;
      9'h172: lut_cell = 6'o71;
      9'h16B: lut_cell = 6'o72;
      9'h174: lut_cell = 6'o73;
      9'h005: lut_cell = 6'o74;
      9'h006: lut_cell = 6'o75;
      9'h004: lut_cell = 6'o76;
      9'h00C: lut_cell = 6'o77;
      default: lut_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dec_hit_q     <= 1'b0;
      dec_rst_q     <= 1'b0;
      dec_pressed_q <= 1'b0;
      dec_cell_q    <= 6'o00;
`ifdef KBD_SHIFTLOCK_EN
      dec_caps_q    <= 1'b0;
`endif
    end else begin
      dec_hit_q     <= ev_valid_q && lut_hit && !is_rst_key;
      dec_rst_q     <= ev_valid_q && is_rst_key;
      dec_pressed_q <= ev_pressed_q;
      dec_cell_q    <= lut_cell;
`ifdef KBD_SHIFTLOCK_EN
      dec_caps_q    <= ev_valid_q && is_caps;
`endif
    end
  end

  // Only a fresh press on an idle counter starts a pulse; release never cuts it short.
  always_comb begin
    nmi_cnt_d = nmi_cnt_q;
    if (dec_rst_q && dec_pressed_q && !reset_key_q && (nmi_cnt_q == 8'd0))
      nmi_cnt_d = NMI_LOAD;
    else if (nmi_cnt_q != 8'd0)
      nmi_cnt_d = nmi_cnt_q - 8'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      matrix_q    <= '0;
      any_key_q   <= 1'b0;
      reset_key_q <= 1'b0;
      nmi_cnt_q   <= 8'd0;
`ifdef KBD_SHIFTLOCK_EN
      shift_lock_q <= 1'b0;
      caps_held_q  <= 1'b0;
`endif
    end else begin
      if (dec_hit_q)
        matrix_q[dec_cell_q[5:3]][dec_cell_q[2:0]] <= dec_pressed_q;
      if (dec_rst_q)
        reset_key_q <= dec_pressed_q;
      nmi_cnt_q <= nmi_cnt_d;
`ifdef KBD_SHIFTLOCK_EN
      if (dec_caps_q) begin
        caps_held_q <= dec_pressed_q;
        if (dec_pressed_q && !caps_held_q)
          shift_lock_q <= !shift_lock_q;
      end
      any_key_q <= (|matrix_q) | shift_lock_q;
`else
      any_key_q <= |matrix_q;
`endif
    end
  end

  always_comb begin
    key_cols_o = matrix_q[key_row_i];
`ifdef KBD_SHIFTLOCK_EN
    if (shift_lock_q && (key_row_i == 3'd0))
      key_cols_o[2] = 1'b1;
`endif
  end

  assign any_key_o   = any_key_q;
  assign reset_key_o = reset_key_q;
  assign nmi_req_o   = (nmi_cnt_q != 8'd0);

endmodule

// File: tb/tb_sordm5_ps2_matrix.sv
// Bench for sordm5_ps2_matrix: directed literal checks plus randomized events against an event-timeline model.
module tb_sordm5_ps2_matrix;

  localparam int NMI = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key = 11'h000;
  logic [2:0]  key_row = 3'd0;
  logic [7:0]  key_cols;
  logic        any_key;
  logic        reset_key;
  logic        nmi_req;

  sordm5_ps2_matrix #(.NMI_PULSE_CYCLES(NMI), .RESET_KEY_CODE(8'h69)) dut (
    .clk_i(clk), .reset_i(reset), .ps2_key_i(ps2_key), .key_row_i(key_row),
    .key_cols_o(key_cols), .any_key_o(any_key), .reset_key_o(reset_key), .nmi_req_o(nmi_req)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each event takes effect on the matrix at a known edge: capture edge + 2.
  typedef struct { int at; bit pressed; bit ext; logic [7:0] code; } ev_t;
  ev_t ev_q[$];
  logic [7:0] mdl [8];
  bit  mdl_rk;
  int  nmi_end;
  bit  sl, caps_held;
  bit  prev_any;

  function automatic bit map_key(input bit ext, input logic [7:0] code, output int r, output int c);
    r = 0; c = 0;
    case ({ext, code})
      9'h014, 9'h114: begin r = 0; c = 0; return 1; end
      9'h012: begin r = 0; c = 2; return 1; end
      9'h059: begin r = 0; c = 3; return 1; end
      9'h029: begin r = 0; c = 6; return 1; end
      9'h05A: begin r = 0; c = 7; return 1; end
      9'h016: begin r = 1; c = 0; return 1; end
      9'h01C: begin r = 2; c = 0; return 1; end
      default: return 0;
    endcase
  endfunction

  task automatic apply(input ev_t e);
    int r, c;
    if (e.ext && e.code == 8'h69) begin
      if (e.pressed && !mdl_rk && e.at >= nmi_end) nmi_end = e.at + NMI;
      mdl_rk = e.pressed;
    end
`ifdef KBD_SHIFTLOCK_EN
    else if (!e.ext && e.code == 8'h58) begin
      if (e.pressed && !caps_held) sl = !sl;
      caps_held = e.pressed;
    end
`endif
    else if (map_key(e.ext, e.code, r, c)) mdl[r][c] = e.pressed;
  endtask

  function automatic logic [7:0] exp_row(input int r);
    logic [7:0] v;
    v = mdl[r];
    if (r == 0 && sl) v[2] = 1'b1;
    return v;
  endfunction

  function automatic bit exp_any();
    bit a;
    a = 0;
    for (int i = 0; i < 8; i++) a |= (exp_row(i) != 8'h00);
    return a;
  endfunction

  task automatic clear_model();
    ev_q.delete();
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    mdl_rk = 0; nmi_end = 0; sl = 0; caps_held = 0; prev_any = 0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      while (ev_q.size() > 0 && ev_q[0].at <= edge_cnt) begin
        apply(ev_q[0]);
        void'(ev_q.pop_front());
      end
      check("cols", key_cols, exp_row(int'(key_row)));
      check("any_key", any_key, prev_any);
      check("reset_key", reset_key, mdl_rk);
      check("nmi_req", nmi_req, edge_cnt < nmi_end);
      prev_any = exp_any();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit pressed, input bit ext, input logic [7:0] code);
    ev_t e;
    @(posedge clk); #1;
    ps2_key = {~ps2_key[10], pressed, ext, code};
    e.at = edge_cnt + 3; e.pressed = pressed; e.ext = ext; e.code = code;
    ev_q.push_back(e);
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    clear_model();
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [8:0] pool [12] = '{9'h014, 9'h114, 9'h012, 9'h059, 9'h029, 9'h05A,
                            9'h016, 9'h01C, 9'h069, 9'h11C, 9'h169, 9'h058};
  int nmi_cnt;

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    release_reset();
    key_row = 3'd2;
    negs(2);
    check("rst_cols", key_cols, 8'h00);
    check("rst_any", any_key, 1'b0);
    check("rst_rkey", reset_key, 1'b0);
    check("rst_nmi", nmi_req, 1'b0);

    // 'A' make: visible exactly two cycles after capture, any_key one later
    send(1, 0, 8'h1C);
    negs(3); check("a_make_early", key_cols, 8'h00);
    negs(1); check("a_make_cols", key_cols, 8'h01); check("a_make_any_early", any_key, 1'b0);
    negs(1); check("a_make_any", any_key, 1'b1);
    send(0, 0, 8'h1C);
    negs(5); check("a_break_cols", key_cols, 8'h00); check("a_break_any", any_key, 1'b0);

    // LSHIFT + RETURN back to back
    key_row = 3'd0;
    send(1, 0, 8'h12);
    send(1, 0, 8'h5A);
    negs(4); check("row0_84", key_cols, 8'h84);
    #1 key_row = 3'd1;
    #1 check("row1_same_cycle", key_cols, 8'h00);
    #1 key_row = 3'd0;

    // Aliased CTRL cell
    send(1, 0, 8'h14); negs(4); check("ctrl_make", key_cols[0], 1'b1);
    send(1, 1, 8'h14); negs(4); check("rctrl_make", key_cols[0], 1'b1);
    send(0, 1, 8'h14); negs(4); check("rctrl_break", key_cols[0], 1'b0);

    // RESET key: re-press mid-pulse and release mid-pulse leave width at 16
    nmi_cnt = 0;
    send(1, 1, 8'h69);
    fork
      begin
        repeat (40) begin @(negedge clk); if (nmi_req) nmi_cnt++; end
      end
      begin
        repeat (4) @(posedge clk);
        send(1, 1, 8'h69);
        repeat (2) @(posedge clk);
        send(0, 1, 8'h69);
      end
    join
    check("nmi_width", nmi_cnt, NMI);
    check("rkey_released", reset_key, 1'b0);

    // Async reset during a pulse
    send(1, 1, 8'h69);
    repeat (6) @(posedge clk);
    #1 check("nmi_mid_pulse", nmi_req, 1'b1);
    assert_reset();
    #1 check("nmi_reset_drop", nmi_req, 1'b0);
    check("cols_reset_drop", key_cols, 8'h00);
    release_reset();

    // CapsLock make, break, make
    key_row = 3'd0;
    send(1, 0, 8'h58); negs(5);
`ifdef KBD_SHIFTLOCK_EN
    check("caps_on", key_cols, 8'h04); check("caps_on_any", any_key, 1'b1);
`else
    check("caps_on", key_cols, 8'h00); check("caps_on_any", any_key, 1'b0);
`endif
    send(0, 0, 8'h58); negs(5);
`ifdef KBD_SHIFTLOCK_EN
    check("caps_break", key_cols, 8'h04);
`else
    check("caps_break", key_cols, 8'h00);
`endif
    send(1, 0, 8'h58); negs(5); check("caps_off", key_cols, 8'h00);
    send(0, 0, 8'h58);

    // Held toggle=1 across reset must not replay the last event
    send(1, 0, 8'h1C);
    if (!ps2_key[10]) send(1, 0, 8'h1C);
    negs(6);
    @(posedge clk); #1;
    assert_reset();
    release_reset();
    key_row = 3'd2;
    negs(6); check("no_spurious", key_cols, 8'h00);

    // Randomized events, gaps, row selects and occasional async reset
    for (int i = 0; i < 600; i++) begin
      logic [8:0] k;
      int gap;
      k = pool[$urandom_range(0, 11)];
      gap = $urandom_range(0, 3);
      if (gap > 1) repeat (gap - 1) @(posedge clk);
      send($urandom_range(0, 1) == 1, k[8], k[7:0]);
      key_row = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        #2 assert_reset();
        #1 check("rand_reset_nmi", nmi_req, 1'b0);
        release_reset();
      end
    end
    repeat (30) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
